fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO; next generation of the fixed 64-bit fifo_main buffer.
- Adds configurable width, power-of-two depth, occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer stages in the datapath; both sides share one clock.

---
 rtl/fifo_sync_param.sv | 105 ++++++++++
 tb/tb_fifo_sync_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
module fifo_sync_param #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [CW-1:0] AfLevel   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeLevel   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full_q, empty_q, almostFull_q, almostEmpty_q;
  logic             overflow_q, underflow_q;
  logic             wrAccept, rdAccept;

  // Acceptance is judged against the registered flags, so a full FIFO rejects a
  // write even when a read frees a slot on the same edge (and likewise for empty).
  always_comb begin
    wrAccept = wr_en && !full_q;
    rdAccept = rd_en && !empty_q;
    wrPtr_d  = wrAccept ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d  = rdAccept ? rdPtr_q + AW'(1) : rdPtr_q;
    count_d  = count_q;
    if (wrAccept && !rdAccept) begin
      count_d = count_q + CW'(1);
    end else if (rdAccept && !wrAccept) begin
      count_d = count_q - CW'(1);
    end
    dout_d = rdAccept ? mem[rdPtr_q] : dout_q;
  end

  // Flags are computed from the next count so they line up with count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      dout_q        <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      dout_q        <= dout_d;
      full_q        <= (count_d == FullCount);
      empty_q       <= (count_d == '0);
      almostFull_q  <= (count_d >= AfLevel);
      almostEmpty_q <= (count_d <= AeLevel);
      overflow_q    <= wr_en && full_q;
      underflow_q   <= rd_en && empty_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wrAccept) begin
      mem[wrPtr_q] <= din;
    end
  end

  // In FWFT mode the head word is shown directly; forced to zero while empty.
  generate
    if (FWFT != 0) begin : gFwft
      assign dout = empty_q ? '0 : mem[rdPtr_q];
    end else begin : gStd
      assign dout = dout_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almostFull_q;
  assign almost_empty = almostEmpty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: a standard-read FIFO and a FWFT FIFO, each with a queue of
// expected words filled by the stimulus and drained by an independent monitor.
module tb_fifo_sync_param;

  logic        clk;
  logic        rst0, wr0, rd0, rst1, wr1, rd1;
  logic [63:0] din0, din1, dout0, dout1;
  logic        full0, empty0, af0, ae0, ovf0, unf0;
  logic        full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]  count0, count1;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [63:0] expQ0[$];
  logic [63:0] expQ1[$];
  logic        pend0 = 1'b0;

  fifo_sync_param #(.WIDTH(64), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst0), .din(din0), .wr_en(wr0), .rd_en(rd0), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0));

  fifo_sync_param #(.WIDTH(64), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst1), .din(din1), .wr_en(wr1), .rd_en(rd1), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [63:0] d);
    wr0 = w; rd0 = r; din0 = d;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus1(input logic w, input logic r, input logic [63:0] d);
    wr1 = w; rd1 = r; din1 = d;
    @(posedge clk); #1;
  endtask

  // Standard mode: data for a read accepted at one edge is checked the following half-cycle.
  always @(negedge clk) begin
    if (pend0) begin
      if (expQ0.size() == 0) checkOutput("std unexpected read", dout0, 64'hDEAD);
      else checkOutput("std dout", dout0, expQ0.pop_front());
    end
    pend0 = rd0 && !empty0 && !rst0;
  end

  // FWFT mode: the head word must already be on dout when rd_en pops it.
  always @(negedge clk) begin
    if (rd1 && !empty1 && !rst1) begin
      if (expQ1.size() == 0) checkOutput("fwft unexpected read", dout1, 64'hDEAD);
      else checkOutput("fwft dout", dout1, expQ1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst0 = 1'b1; wr0 = 1'b0; rd0 = 1'b0; din0 = '0;
    rst1 = 1'b1; wr1 = 1'b0; rd1 = 1'b0; din1 = '0;
    @(posedge clk); #1;

    // Reset with both requests high
    applyStimulus(1, 1, 64'h55);
    applyStimulus(1, 1, 64'h55);
    rst0 = 1'b0; wr0 = 0; rd0 = 0;
    checkOutput("rst count", count0, 0);
    checkOutput("rst empty", empty0, 1);
    checkOutput("rst full", full0, 0);
    checkOutput("rst dout", dout0, 0);
    checkOutput("rst almost_empty", ae0, 1);
    checkOutput("rst almost_full", af0, 0);
    checkOutput("rst overflow", ovf0, 0);
    checkOutput("rst underflow", unf0, 0);

    // Fill to full, then one rejected write
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, 0, 64'(i));
      expQ0.push_back(64'(i));
      checkOutput("fill count", count0, 64'(i));
      checkOutput("fill almost_full", af0, (i >= 14) ? 1 : 0);
      checkOutput("fill full", full0, (i == 16) ? 1 : 0);
    end
    applyStimulus(1, 0, 64'd17);
    checkOutput("overflow pulse", ovf0, 1);
    checkOutput("overflow count", count0, 16);
    applyStimulus(0, 0, 0);
    checkOutput("overflow cleared", ovf0, 0);

    // Drain, then one rejected read
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 1, 0);
      checkOutput("drain count", count0, 64'(16 - i));
      checkOutput("drain empty", empty0, (i == 16) ? 1 : 0);
      checkOutput("drain almost_empty", ae0, (16 - i <= 2) ? 1 : 0);
    end
    applyStimulus(0, 1, 0);
    checkOutput("underflow pulse", unf0, 1);
    checkOutput("underflow dout held", dout0, 16);
    applyStimulus(0, 0, 0);
    checkOutput("underflow cleared", unf0, 0);
    checkOutput("dout still held", dout0, 16);

    // Pointer wrap
    for (int i = 0; i < 10; i++) begin applyStimulus(1, 0, 64'(100 + i)); expQ0.push_back(64'(100 + i)); end
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0);
    for (int i = 0; i < 12; i++) begin applyStimulus(1, 0, 64'(100 + i)); expQ0.push_back(64'(100 + i)); end
    checkOutput("wrap count 12", count0, 12);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0);
    checkOutput("wrap count 0", count0, 0);

    // Simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) begin applyStimulus(1, 0, 64'(200 + i)); expQ0.push_back(64'(200 + i)); end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 64'(300 + i));
      expQ0.push_back(64'(300 + i));
      checkOutput("simul count", count0, 5);
    end

    // Simultaneous at full: write rejected, read accepted
    for (int i = 0; i < 11; i++) begin applyStimulus(1, 0, 64'(400 + i)); expQ0.push_back(64'(400 + i)); end
    checkOutput("refill full", full0, 1);
    applyStimulus(1, 1, 64'd999);
    checkOutput("full simul overflow", ovf0, 1);
    checkOutput("full simul count", count0, 15);
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0);
    checkOutput("redrain empty", empty0, 1);

    // Simultaneous at empty: read rejected, write accepted
    applyStimulus(1, 1, 64'd555);
    expQ0.push_back(64'd555);
    checkOutput("empty simul underflow", unf0, 1);
    checkOutput("empty simul count", count0, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("std scoreboard drained", 64'(expQ0.size()), 0);

    // FWFT instance
    applyStimulus1(1, 1, 64'h11);
    rst1 = 1'b0;
    applyStimulus1(0, 0, 0);
    checkOutput("fwft rst dout", dout1, 0);
    checkOutput("fwft rst empty", empty1, 1);
    applyStimulus1(1, 0, 64'hA5);
    expQ1.push_back(64'hA5);
    checkOutput("fwft early empty", empty1, 0);
    checkOutput("fwft early dout", dout1, 64'hA5);
    applyStimulus1(0, 1, 0);
    checkOutput("fwft popped empty", empty1, 1);
    for (int i = 0; i < 8; i++) applyStimulus1(1, 0, 64'(16 + i));
    checkOutput("fwft count 8", count1, 8);
    rst1 = 1'b1;
    applyStimulus1(1, 0, 64'h99);
    rst1 = 1'b0;
    wr1 = 0;
    checkOutput("fwft midrst count", count1, 0);
    checkOutput("fwft midrst empty", empty1, 1);
    checkOutput("fwft midrst dout", dout1, 0);
    applyStimulus1(1, 0, 64'h77);
    expQ1.push_back(64'h77);
    checkOutput("fwft after rst dout", dout1, 64'h77);
    applyStimulus1(0, 1, 0);
    applyStimulus1(0, 0, 0);
    checkOutput("fwft scoreboard drained", 64'(expQ1.size()), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
